hd_bitop_arbiter: RTL and testbench
===================================

Name: hd_bitop_arbiter

Overview:
- Shares one 8-bit bit-manipulation kernel (rightmost-bit isolate/clear/propagate family) between NREQ requesters.
- Round-robin arbitration, one registered result stage with valid/ready backpressure, and a requester tag returned with each result.
- Sits between requester clients and downstream consumers.
- The kernel is a combinational sub-module; this block does all sequencing and buffering.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand/result width.
- IDW, 2, tag width; must equal clog2(NREQ).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_op  in  NREQ*3  per-requester opcode, requester i at bits [3i+2:3i].
- req_x  in  NREQ*W  per-requester operand, requester i at bits [Wi+W-1:Wi].
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  downstream accepts the result.
- out_res  out  W  kernel result.
- out_id  out  IDW  index of the requester that produced the result.
- out_err  out  1  opcode was illegal (6 or 7).

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_res=0, out_id=0, out_err=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 while rst_n is low.
- Opcodes, all arithmetic modulo 2^W:
  - 0: x & -x, isolate rightmost 1.
  - 1: ~x & (x+1), isolate rightmost 0.
  - 2: x & (x-1), clear rightmost 1.
  - 3: ~x & (x-1), mask trailing zeros.
  - 4: x | (x-1), right-propagate rightmost 1.
  - 5: ((x | (x-1)) + 1) & x, clear rightmost contiguous 1s.
  - 6, 7: result 0, out_err=1.
- can_accept = !out_valid | out_ready (pass-through when the output drains in the same cycle).
- Grant (combinational):
  - Pick the first i with req_valid[i] set, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
  - req_ready[i]=1 only for that i, and only when can_accept=1.
  - req_ready does not depend on req_op or req_x.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. Requesters hold op and x stable while valid and not ready. A requester may drop req_valid without penalty.
- On transfer at edge t:
  - out_res, out_id and out_err load the kernel output for the granted request.
  - out_valid=1 from cycle t+1. Latency is 1 cycle.
  - rr_ptr = (granted+1) mod NREQ.
- No transfer and out_ready=1 while out_valid=1: out_valid clears next cycle.
- No transfer: rr_ptr holds.
- Backpressure: out_valid=1 with out_ready=0 holds out_res, out_id and out_err stable, and all req_ready=0.
- Simultaneous pop and push: the old result is consumed and the new one loaded in the same edge; no bubble. Full throughput is 1 result/cycle.
- Fairness: with all NREQ requesters continuously valid and out_ready=1, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 grants.
- x=0 edge values: op0→0, op1→0x01, op2→0, op3→0xFF, op4→0xFF, op5→0.
- Reset mid-operation: the pending result is discarded, out_valid drops immediately (async), rr_ptr=0.

Decomposition:
- Package hd_bitop_pkg:
  - opcode enum: OP_ISO1=0, OP_ISO0=1, OP_CLR1=2, OP_TZMSK=3, OP_PROP1=4, OP_CLRRUN=5.
  - OP_W=3.
  - function is_legal_op.
- Sub-module hd_bitop_kernel: purely combinational; inputs op and x, outputs res and err, width W. Reused standalone for synthesis benchmarking.
- The arbiter (a rotate-priority encoder) stays inline.

Test Plan:
- Single requester 0: op=0, x=0xB4, out_ready=1 → one cycle later out_valid=1, out_res=0x04, out_id=0, out_err=0.
- Opcode sweep on requester 2 (x=0xB4 unless noted) → results:
  - op1 on x=0xB7 → 0x08.
  - op2 → 0xB0.
  - op3 → 0x03.
  - op4 → 0xB7.
  - op5 on x=0x5C → 0x40.
  - op6 → res 0, err=1.
- All four valid continuously, out_ready=1 → out_id sequence 0,1,2,3,0,1. One result per cycle, no bubbles.
- Backpressure:
  - Requesters 1 and 3 valid, out_ready=0 for 5 cycles after the first result → out_res/out_id frozen (id=1), req_ready=0.
  - On out_ready=1, next result has id=3.
- rr_ptr=2, only requester 0 valid → granted requester 0 and rr_ptr becomes 1. x=0 with op3 → 0xFF, op1 → 0x01.
- Assert rst_n low while out_valid=1 and backpressured → out_valid=0 without a clock edge.
  - After release, requesters 3 and 0 both valid → requester 0 granted first (rr_ptr=0).

Source files
------------

// File: rtl/hd_bitop_pkg.sv
// Shared definitions for the rightmost-bit manipulation kernel and its arbiter.
package hd_bitop_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ISO1   = 3'd0,  // x & -x
        OP_ISO0   = 3'd1,  // ~x & (x+1)
        OP_CLR1   = 3'd2,  // x & (x-1)
        OP_TZMSK  = 3'd3,  // ~x & (x-1)
        OP_PROP1  = 3'd4,  // x | (x-1)
        OP_CLRRUN = 3'd5   // ((x | (x-1)) + 1) & x
    } op_e;

    // Codes 6 and 7 are reserved and reported as errors.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op <= OP_CLRRUN);
    endfunction

endpackage

// File: rtl/hd_bitop_kernel.sv
// Combinational rightmost-bit kernel: isolate/clear/propagate family on a W-bit operand.
module hd_bitop_kernel
    import hd_bitop_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    x,
    output logic [W-1:0]    res,
    output logic            err
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] x_dec;
    logic [W-1:0] x_inc;
    logic [W-1:0] x_neg;

    assign x_dec = x - ONE;
    assign x_inc = x + ONE;
    assign x_neg = ~x + ONE;

    // Select the requested identity; illegal codes yield zero with err set.
    always_comb begin
        res = '0;
        err = !is_legal_op(op);
        case (op)
            OP_ISO1:   res = x & x_neg;
            OP_ISO0:   res = ~x & x_inc;
            OP_CLR1:   res = x & x_dec;
            OP_TZMSK:  res = ~x & x_dec;
            OP_PROP1:  res = x | x_dec;
            OP_CLRRUN: res = ((x | x_dec) + ONE) & x;
            default:   res = '0;
        endcase
    end

endmodule

// File: rtl/hd_bitop_arbiter.sv
// Round-robin arbiter sharing one bit-op kernel among NREQ requesters,
// with a single registered result stage and valid/ready backpressure.
module hd_bitop_arbiter
    import hd_bitop_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_op,
    input  logic [NREQ*W-1:0]    req_x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_res,
    output logic [IDW-1:0]       out_id,
    output logic                 out_err
);

    localparam logic [IDW:0]      NREQ_EXT = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0]    LAST_IDX = IDW'(NREQ-1);
    localparam logic [NREQ-1:0]   ONE_HOT0 = NREQ'(1);

    logic [IDW-1:0]     rr_ptr;
    logic               can_accept;
    logic               gnt_found;
    logic [IDW-1:0]     gnt_off;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW:0]       gnt_sum;
    logic [2*NREQ-1:0]  valid_dbl;
    logic [NREQ-1:0]    valid_rot;
    logic               xfer;

    logic [OP_W-1:0]    op_p0;
    logic [W-1:0]       x_p0;
    logic [W-1:0]       kres_p0;
    logic               kerr_p0;

    logic               vld_p1;
    logic [W-1:0]       res_p1;
    logic [IDW-1:0]     id_p1;
    logic               err_p1;

    // A new result may enter when the register is empty or draining this cycle.
    assign can_accept = !vld_p1 || out_ready;

    // Rotate-priority encoder: rotate valids so rr_ptr sits at bit 0, take the
    // first set bit, then map the offset back to an absolute requester index.
    always_comb begin
        valid_dbl = {req_valid, req_valid} >> rr_ptr;
        valid_rot = valid_dbl[NREQ-1:0];
        gnt_found = 1'b0;
        gnt_off   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && valid_rot[k]) begin
                gnt_found = 1'b1;
                gnt_off   = IDW'(k);
            end
        end
        gnt_sum = {1'b0, rr_ptr} + {1'b0, gnt_off};
        if (gnt_sum >= NREQ_EXT) begin
            gnt_sum = gnt_sum - NREQ_EXT;
        end
        gnt_idx = gnt_sum[IDW-1:0];
    end

    // Grant is a one-hot ready, suppressed under backpressure and during reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && gnt_found && can_accept) begin
            req_ready = ONE_HOT0 << gnt_idx;
        end
    end

    assign xfer = |(req_valid & req_ready);

    // Route the granted requester's opcode and operand to the kernel.
    always_comb begin
        op_p0 = '0;
        x_p0  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (IDW'(k) == gnt_idx) begin
                op_p0 = req_op[k*OP_W +: OP_W];
                x_p0  = req_x[k*W +: W];
            end
        end
    end

    hd_bitop_kernel #(
        .W (W)
    ) u_kernel (
        .op  (op_p0),
        .x   (x_p0),
        .res (kres_p0),
        .err (kerr_p0)
    );

    // ---- stage p0 -> p1: result register ----

    // Valid flag and round-robin pointer: load on transfer, drain on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            rr_ptr <= '0;
        end else if (xfer) begin
            vld_p1 <= 1'b1;
            rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDW'(1);
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    // Result payload: captured only on a transfer, otherwise held stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p1 <= '0;
            id_p1  <= '0;
            err_p1 <= 1'b0;
        end else if (xfer) begin
            res_p1 <= kres_p0;
            id_p1  <= gnt_idx;
            err_p1 <= kerr_p0;
        end
    end

    assign out_valid = vld_p1;
    assign out_res   = res_p1;
    assign out_id    = id_p1;
    assign out_err   = err_p1;

endmodule

// File: tb/tb_hd_bitop_arbiter.sv
// Self-checking bench for hd_bitop_arbiter: directed scenarios plus
// randomized traffic compared every cycle against a behavioural model.
module tb_hd_bitop_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*3-1:0]    req_op;
    logic [NREQ*W-1:0]    req_x;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_res;
    logic [IDW-1:0]       out_id;
    logic                 out_err;

    hd_bitop_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_x     (req_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_id    (out_id),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state
    bit           m_vld;
    logic [W-1:0] m_res;
    int           m_id;
    bit           m_err;
    int           m_rr;
    int           last_gnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference kernel written from the bit-level meaning of each opcode.
    function automatic logic [W-1:0] ref_kern(input int op, input logic [W-1:0] x);
        int p = -1;
        int q = -1;
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            if (p < 0 && x[i])  p = i;
            if (q < 0 && !x[i]) q = i;
        end
        r = '0;
        case (op)
            0: if (p >= 0) r[p] = 1'b1;
            1: if (q >= 0) r[q] = 1'b1;
            2: begin r = x; if (p >= 0) r[p] = 1'b0; end
            3: begin
                if (p < 0) r = '1;
                else for (int i = 0; i < p; i++) r[i] = 1'b1;
            end
            4: begin
                r = x;
                if (p < 0) r = '1;
                else for (int i = 0; i < p; i++) r[i] = 1'b1;
            end
            5: begin
                r = x;
                if (p >= 0) for (int i = p; i < W && x[i]; i++) r[i] = 1'b0;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++) begin
            int idx = (m_rr + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_vld = 0; m_res = '0; m_id = 0; m_err = 0; m_rr = 0; last_gnt = -1;
    endtask

    task automatic compare_all();
        logic [NREQ-1:0] exp_ready;
        int g;
        exp_ready = '0;
        if (rst_n) begin
            g = model_grant();
            if (g >= 0 && (!m_vld || out_ready)) exp_ready[g] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(m_vld));
        check("out_res",   32'(out_res),   32'(m_res));
        check("out_id",    32'(out_id),    32'(m_id));
        check("out_err",   32'(out_err),   32'(m_err));
    endtask

    task automatic model_step();
        int g;
        int op;
        last_gnt = -1;
        if (!rst_n) begin
            model_reset();
        end else begin
            g = model_grant();
            if (g >= 0 && (!m_vld || out_ready)) begin
                op = int'(req_op[3*g +: 3]);
                m_res = ref_kern(op, req_x[W*g +: W]);
                m_err = (op > 5);
                m_id  = g;
                m_vld = 1;
                m_rr  = (g + 1) % NREQ;
                last_gnt = g;
            end else if (out_ready) begin
                m_vld = 0;
            end
        end
    endtask

    // Compare at the falling edge, advance the model, then return just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        compare_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] op, input logic [W-1:0] x);
        req_valid[i]       = v;
        req_op[3*i +: 3]   = op;
        req_x[W*i +: W]    = x;
    endtask

    task automatic idle();
        req_valid = '0;
        req_op    = '0;
        req_x     = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        cycle();
        rst_n = 1'b1;
    endtask

    // Requests that are pending keep their payload; others are refreshed at random.
    task automatic rand_step();
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && last_gnt != i) begin
                if ($urandom % 5 == 0) req_valid[i] = 1'b0;
            end else begin
                set_req(i, 1'($urandom % 2), 3'($urandom % 8), W'($urandom));
            end
        end
        out_ready = ($urandom % 4) != 0;
    endtask

    typedef struct { int op; int x; int res; int err; } sweep_t;
    sweep_t sweep [6] = '{
        '{1, 8'hB7, 8'h08, 0},
        '{2, 8'hB4, 8'hB0, 0},
        '{3, 8'hB4, 8'h03, 0},
        '{4, 8'hB4, 8'hB7, 0},
        '{5, 8'h5C, 8'h40, 0},
        '{6, 8'hB4, 8'h00, 1}
    };

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        idle();
        model_reset();

        // Pin the reference kernel to hand-computed values.
        check("ref_op0_b4",  32'(ref_kern(0, 8'hB4)), 32'h04);
        check("ref_op1_b7",  32'(ref_kern(1, 8'hB7)), 32'h08);
        check("ref_op5_5c",  32'(ref_kern(5, 8'h5C)), 32'h40);
        check("ref_op3_00",  32'(ref_kern(3, 8'h00)), 32'hFF);
        check("ref_op4_00",  32'(ref_kern(4, 8'h00)), 32'hFF);
        check("ref_op1_00",  32'(ref_kern(1, 8'h00)), 32'h01);
        check("ref_op1_ff",  32'(ref_kern(1, 8'hFF)), 32'h00);

        // Reset state
        cycle();
        cycle();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_res",   32'(out_res),   0);
        check("rst_out_id",    32'(out_id),    0);
        check("rst_req_ready", 32'(req_ready), 0);
        rst_n = 1'b1;

        // Single requester 0
        out_ready = 1'b1;
        set_req(0, 1'b1, 3'd0, 8'hB4);
        cycle();
        check("single_valid", 32'(out_valid), 1);
        check("single_res",   32'(out_res),   32'h04);
        check("single_id",    32'(out_id),    0);
        check("single_err",   32'(out_err),   0);
        set_req(0, 1'b0, 3'd0, 8'h00);

        // Opcode sweep on requester 2, back to back
        foreach (sweep[n]) begin
            set_req(2, 1'b1, 3'(sweep[n].op), 8'(sweep[n].x));
            cycle();
            check($sformatf("sweep_op%0d_res", sweep[n].op), 32'(out_res), 32'(sweep[n].res));
            check($sformatf("sweep_op%0d_err", sweep[n].op), 32'(out_err), 32'(sweep[n].err));
            check($sformatf("sweep_op%0d_id",  sweep[n].op), 32'(out_id),  2);
            check($sformatf("sweep_op%0d_vld", sweep[n].op), 32'(out_valid), 1);
        end
        idle();
        cycle();

        // Fairness: all requesters continuously valid
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 3'd2, 8'(8'h11 * (i + 1)));
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            cycle();
            check($sformatf("rr_id%0d", n), 32'(out_id), 32'(n % NREQ));
            check($sformatf("rr_vld%0d", n), 32'(out_valid), 1);
        end
        idle();
        cycle();

        // Backpressure with requesters 1 and 3
        do_reset();
        set_req(1, 1'b1, 3'd0, 8'h10);
        set_req(3, 1'b1, 3'd2, 8'h0F);
        out_ready = 1'b1;
        cycle();
        check("bp_first_id", 32'(out_id), 1);
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            cycle();
            check("bp_hold_id",    32'(out_id),    1);
            check("bp_hold_res",   32'(out_res),   32'h10);
            check("bp_hold_ready", 32'(req_ready), 0);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_next_id",  32'(out_id),  3);
        check("bp_next_res", 32'(out_res), 32'h0E);
        idle();
        cycle();

        // rr_ptr=2 with only requester 0 valid; x=0 edge values
        set_req(1, 1'b1, 3'd0, 8'h01);
        cycle();
        set_req(1, 1'b0, 3'd0, 8'h00);
        set_req(0, 1'b1, 3'd3, 8'h00);
        cycle();
        check("wrap_id",      32'(out_id),  0);
        check("wrap_op3_x0",  32'(out_res), 32'hFF);
        set_req(0, 1'b1, 3'd1, 8'h00);
        cycle();
        check("wrap2_id",     32'(out_id),  0);
        check("wrap_op1_x0",  32'(out_res), 32'h01);
        idle();
        cycle();

        // Asynchronous reset while backpressured
        set_req(2, 1'b1, 3'd4, 8'h30);
        out_ready = 1'b0;
        cycle();
        check("arst_pre_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_ready", 32'(req_ready), 0);
        cycle();
        rst_n = 1'b1;
        idle();
        set_req(3, 1'b1, 3'd0, 8'h0C);
        set_req(0, 1'b1, 3'd0, 8'h30);
        out_ready = 1'b1;
        cycle();
        check("arst_after_id",  32'(out_id),  0);
        check("arst_after_res", 32'(out_res), 32'h10);

        // Randomized traffic
        idle();
        for (int n = 0; n < 3000; n++) begin
            rand_step();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
